// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: blank pattern, hex glyphs
// and the per-slot state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational 4-bit to active-low 7-segment decoder, shared by all digits.
module hex7seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = hex_glyph(i_nib);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment controller with frame-aligned word commit.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks digits above the top nonzero nibble.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    output logic                    load_ready,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_act_data;
    logic [NUM_DIGITS-1:0]   r_act_dp;
    logic [4*NUM_DIGITS-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_ready;
    logic [NUM_DIGITS-1:0]   r_an_n;
    logic [6:0]              r_seg_n;
    logic                    r_dp_n;

    state_t                  w_state;
    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_accept;
    logic                    w_commit;
    logic [3:0]              w_nib;
    logic                    w_dp_bit;
    logic [NUM_DIGITS-1:0]   w_an_drive;
    logic [6:0]              w_seg;
    logic                    w_show;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic [6:0]              w_seg_nxt;
    logic                    w_dp_nxt;

    assign w_state     = (r_cnt < CNT_BLANK) ? BLANK : DRIVE;
    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
    assign w_accept    = load_valid && r_ready;
    // Ready low means a word is pending; it commits only on a frame boundary.
    assign w_commit    = !r_ready && w_frame_end;

    always_comb begin
        w_nib      = 4'h0;
        w_dp_bit   = 1'b0;
        w_an_drive = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib         = r_act_data[4*i +: 4];
                w_dp_bit      = r_act_dp[i];
                w_an_drive[i] = 1'b0;
            end
        end
    end

    hex7seg_decode u_decode (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] w_msd;

    always_comb begin
        w_msd = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_act_data[4*i +: 4] != 4'h0) begin
                w_msd = IDX_W'(i);
            end
        end
        // An all-zero word leaves w_msd at 0, so digit 0 always shows.
        w_show = (r_idx <= w_msd);
    end
`else
    assign w_show = 1'b1;
`endif

    always_comb begin
        w_an_nxt  = '1;
        w_seg_nxt = SEG_OFF;
        w_dp_nxt  = 1'b1;
        if (en && (w_state == DRIVE)) begin
            w_dp_nxt = ~w_dp_bit;
            if (w_show) begin
                w_an_nxt  = w_an_drive;
                w_seg_nxt = w_seg;
            end else if (w_dp_bit) begin
                w_an_nxt = w_an_drive;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_act_data  <= '0;
            r_act_dp    <= '0;
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_ready     <= 1'b1;
            r_an_n      <= '1;
            r_seg_n     <= SEG_OFF;
            r_dp_n      <= 1'b1;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + CNT_W'(1);
            if (w_slot_end) begin
                r_idx <= w_frame_end ? '0 : r_idx + IDX_W'(1);
            end
            if (w_accept) begin
                r_pend_data <= load_data;
                r_pend_dp   <= load_dp;
                r_ready     <= 1'b0;
            end else if (w_commit) begin
                r_act_data <= r_pend_data;
                r_act_dp   <= r_pend_dp;
                r_ready    <= 1'b1;
            end
            r_an_n  <= w_an_nxt;
            r_seg_n <= w_seg_nxt;
            r_dp_n  <= w_dp_nxt;
        end
    end

    assign load_ready = r_ready;
    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed 7-segment display controller for the SPI FPGA test board. It accepts a NUM_DIGITS-nibble hex word from the SPI receive side over a valid/ready handshake and holds it in a shadow register. At each frame boundary it commits the word, then scans the digits one at a time through a single shared hex-to-7-segment decoder. Anode and segment lines drive the board's common-anode display directly.

## Interface
- NUM_DIGITS, 4: number of display digits (2..8)
- SLOT_CYCLES, 50000: clock cycles per digit slot (≥ 4)
- BLANK_CYCLES, 2: anti-ghost cycles at slot start, all anodes off (< SLOT_CYCLES)
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  display enable; low = all anodes off, scan continues
- load_valid  in  1  new display word offered
- load_data  in  4*NUM_DIGITS  nibble i shown on digit i (digit 0 = rightmost)
- load_dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
- load_ready  out  1  controller can accept a word
- an_n  out  NUM_DIGITS  digit anodes, active-low
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_n  out  1  decimal point, active-low

## Operation
- Slot counter counts 0..SLOT_CYCLES-1. Digit index advances 0→1→…→NUM_DIGITS-1→0 on counter wrap. Frame boundary = wrap while index = NUM_DIGITS-1.
- Two-state FSM per slot:
  - BLANK: counter < BLANK_CYCLES; an_n all 1, seg_n 7'h7F, dp_n 1.
  - DRIVE: remainder of the slot; an_n has only bit idx low, seg_n = decode(active nibble idx), dp_n = ~active_dp[idx].
- Decode, active-low: 0→7'b1000000, 1→7'b1111001, 8→7'b0000000, A→7'b0001000, F→7'b0001110. Full 0–F hex set.
- Handshake:
  - Transfer when load_valid & load_ready. Data and dp go into the pending register, and load_ready falls the next cycle.
  - The commit copies pending into the active register. It happens at the first frame boundary strictly after the accept cycle, so a frame is never torn.
  - load_ready rises the cycle after the commit.
  - While load_ready is low, load_valid is ignored; the source holds data until ready.
- en low forces all-off outputs only. The counter, index and handshake keep running, and commits still occur.
- Reset mid-operation: every register returns to its reset value on the next clk edge with rst_n low. Pending data is discarded.

## Timing
- Reset values: an_n all 1, seg_n 7'h7F, dp_n 1, load_ready 1, counter 0, index 0, active/pending 0.
- All outputs registered. Output changes lag the internal counter/index state by 1 cycle.
- The first DRIVE after reset is digit 0 showing "0", at cycle BLANK_CYCLES+1 after rst_n rises.
- Frame period = NUM_DIGITS*SLOT_CYCLES cycles.
- Worst-case accept-to-display latency: one frame plus BLANK_CYCLES+1 cycles.
- An accept on the frame-boundary cycle itself commits at the following boundary.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined:
  - Digits above the most significant nonzero active nibble are blanked during DRIVE: an_n all 1, seg_n 7'h7F.
  - Exception: such a digit keeps its anode and dp if its dp bit is set.
  - Digit 0 is always shown.
- SEG7_LEADING_ZERO_BLANK_EN undefined: every digit is always shown.

## Structure
- Package seg7_pkg holds:
  - the segment constants (SEG_OFF = 7'h7F, hex glyph table);
  - the FSM state enum {BLANK, DRIVE}.
- Sub-module hex7seg_decode: a combinational 4-bit → 7-bit active-low decoder, instantiated once and fed by a mux on the digit index.

## Test plan
- Reset, then run 1 frame with default parameters → digits 0..3 each show 7'b1000000 in turn, an_n = 1110, 1101, 1011, 0111, with a 2-cycle all-off gap per slot.
- Load 16'hA1F8 with dp = 4'b0010 mid-frame → old value stays until the boundary; next frame shows 8, F with dp_n = 0, 1, A. load_ready is low from accept+1 until commit+1.
- Present load_valid while load_ready is low with 16'h1234 → ignored; holding valid → accepted once ready returns, displayed one frame later.
- Drive en = 0 for 1 frame → an_n all 1 throughout; a load during this time commits normally and is visible once en returns.
- Assert rst_n = 0 in the DRIVE state of digit 2 with a pending word → next cycle all outputs at reset values; the pending word is never displayed.
- With SEG7_LEADING_ZERO_BLANK_EN, load 16'h0005 → only digit 0 lit (7'b0010010). Then load 16'h0005 with dp = 4'b0100 → digits 0 and 2 lit, and digit 2 shows only dp_n = 0.
